// File: rtl/div_pkg.sv
// Shared types and constants for the ratio-programmable clock divider.
package div_pkg;

    localparam int DIV_W_DEF = 8;
    localparam int MIN_DIV   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic logic ratio_ok(input logic [31:0] n);
        return n >= 32'(MIN_DIV);
    endfunction

endpackage

// File: rtl/div_core.sv
// Period counter: boundary compare, registered tick pulse and clk_out toggle.
module div_core
    import div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             cnt_en_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_div_i,
    output logic [DIV_W-1:0] count_o,
    output logic [DIV_W-1:0] cur_div_o,
    output logic             tick_o,
    output logic             clk_out_o,
    output logic             boundary_o
);

    logic [DIV_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;

    // The last cycle of a period; only meaningful while counting.
    assign boundary_o = cnt_en_i && (count_q == cur_div_q - DIV_W'(1));

    always_comb begin
        count_d   = count_q;
        cur_div_d = cur_div_q;
        tick_d    = 1'b0;
        clk_d     = clk_q;
        if (!cnt_en_i) begin
            count_d = '0;
        end else if (boundary_o) begin
            count_d = '0;
            tick_d  = 1'b1;
            clk_d   = ~clk_q;
        end else begin
            count_d = count_q + DIV_W'(1);
        end
        if (load_i) begin
            cur_div_d = load_div_i;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            count_q   <= '0;
            cur_div_q <= '0;
            tick_q    <= 1'b0;
            clk_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            cur_div_q <= cur_div_d;
            tick_q    <= tick_d;
            clk_q     <= clk_d;
        end
    end

    assign count_o   = count_q;
    assign cur_div_o = cur_div_q;
    assign tick_o    = tick_q;
    assign clk_out_o = clk_q;

endmodule

// File: rtl/div_ratio_ctrl.sv
// Divider controller: run/drain FSM, ratio handshake and the pending-ratio register.
module div_ratio_ctrl
    import div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             tick,
    output logic             clk_out,
    output logic [DIV_W-1:0] cur_div,
    output logic             running,
    output state_e           dbg_state,
    output logic [DIV_W-1:0] dbg_count,
    output logic             dbg_pend_vld
);

    state_e           state_q, state_d;
    logic             pend_vld_q, pend_vld_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             cfg_err_q, cfg_err_d;

    logic             accept;
    logic             ratio_good;
    logic             core_en;
    logic             core_load;
    logic [DIV_W-1:0] core_load_div;
    logic             boundary;

    // Handshake: a ratio transfers on any rising edge with cfg_valid && cfg_ready.
    // Ready drops while a ratio waits for the next boundary and for the whole
    // drain. A transferred ratio below MIN_DIV is consumed but only raises cfg_err.
    assign cfg_ready  = !pend_vld_q && (state_q != DRAIN);
    assign accept     = cfg_valid && cfg_ready;
    assign ratio_good = ratio_ok(32'(cfg_div));
    assign core_en    = (state_q != IDLE);

    always_comb begin
        state_d       = state_q;
        pend_vld_d    = pend_vld_q;
        pend_div_d    = pend_div_q;
        cfg_err_d     = accept && !ratio_good;
        core_load     = 1'b0;
        core_load_div = cfg_div;
        case (state_q)
            IDLE: begin
                if (accept && ratio_good) begin
                    core_load = 1'b1;
                end
                if (enable && (cur_div >= DIV_W'(MIN_DIV))) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (boundary && pend_vld_q) begin
                    core_load     = 1'b1;
                    core_load_div = pend_div_q;
                    pend_vld_d    = 1'b0;
                end
                // Acceptance needs pend_vld_q low, so it never collides with the apply above.
                if (accept && ratio_good) begin
                    pend_vld_d = 1'b1;
                    pend_div_d = cfg_div;
                end
                if (!enable) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (boundary && pend_vld_q) begin
                    core_load     = 1'b1;
                    core_load_div = pend_div_q;
                    pend_vld_d    = 1'b0;
                end
                // Finish only on the boundary that takes clk_out from 1 to 0.
                if (boundary && clk_out) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= IDLE;
            pend_vld_q <= 1'b0;
            pend_div_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_vld_q <= pend_vld_d;
            pend_div_q <= pend_div_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    div_core #(
        .DIV_W(DIV_W)
    ) u_core (
        .clk_in     (clk_in),
        .reset      (reset),
        .cnt_en_i   (core_en),
        .load_i     (core_load),
        .load_div_i (core_load_div),
        .count_o    (dbg_count),
        .cur_div_o  (cur_div),
        .tick_o     (tick),
        .clk_out_o  (clk_out),
        .boundary_o (boundary)
    );

    assign cfg_err      = cfg_err_q;
    assign running      = (state_q == RUN) || (state_q == DRAIN);
    assign dbg_state    = state_q;
    assign dbg_pend_vld = pend_vld_q;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Bench for div_ratio_ctrl: directed scenarios plus a randomized run against a deadline-based model.
module tb_div_ratio_ctrl;
    import div_pkg::*;

    localparam int W = 8;

    logic         clk_in = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_div = '0;
    logic         cfg_ready, cfg_err, tick, clk_out, running, dbg_pend_vld;
    logic [W-1:0] cur_div, dbg_count;
    state_e       dbg_state;

    int n_checks = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];

    div_ratio_ctrl #(.DIV_W(W)) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .enable       (enable),
        .cfg_valid    (cfg_valid),
        .cfg_div      (cfg_div),
        .cfg_ready    (cfg_ready),
        .cfg_err      (cfg_err),
        .tick         (tick),
        .clk_out      (clk_out),
        .cur_div      (cur_div),
        .running      (running),
        .dbg_state    (dbg_state),
        .dbg_count    (dbg_count),
        .dbg_pend_vld (dbg_pend_vld)
    );

    // ---------------- clock ----------------
    always #5 clk_in = ~clk_in;

    // ---------------- reference model ----------------
    // Tracks the absolute edge index of the next period boundary instead of a counter.
    int cyc = 0;
    bit m_active = 0, m_stopping = 0, m_level = 0, m_tick = 0, m_err = 0;
    int m_n = 0, m_pend = 0, m_next = 0;

    always @(posedge clk_in) begin : ref_model
        bit was_active, was_stopping, rdy;
        int old_n;
        cyc = cyc + 1;
        if (reset) begin
            m_active = 0; m_stopping = 0; m_level = 0; m_tick = 0; m_err = 0;
            m_n = 0; m_pend = 0; m_next = 0;
        end else begin
            was_active   = m_active;
            was_stopping = m_stopping;
            old_n        = m_n;
            rdy          = (m_pend == 0) && !m_stopping;
            m_tick = 0;
            m_err  = 0;
            if (m_active && cyc == m_next) begin
                m_tick  = 1;
                m_level = !m_level;
                if (m_pend != 0) begin
                    m_n    = m_pend;
                    m_pend = 0;
                end
                m_next = cyc + m_n;
                if (m_stopping && !m_level) begin
                    m_active   = 0;
                    m_stopping = 0;
                end
            end
            if (cfg_valid && rdy) begin
                if (int'(cfg_div) < 2) m_err = 1;
                else if (!was_active) m_n = int'(cfg_div);
                else m_pend = int'(cfg_div);
            end
            if (!was_active && enable && old_n >= 2) begin
                m_active = 1;
                m_next   = cyc + m_n;
            end else if (was_active && !was_stopping && !enable) begin
                m_stopping = 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clk_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        clk_step();
        reset = 1'b0;
    endtask

    task automatic start_run(input logic [W-1:0] n, output int start);
        do_reset();
        cfg_valid = 1'b1; cfg_div = n;
        clk_step();
        cfg_valid = 1'b0;
        enable = 1'b1;
        clk_step();
        start = cyc;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; cfg_valid = 1'b1; cfg_div = 8'd9;
        clk_step();
        n_checks++; if (dbg_state !== IDLE) $display("FAIL reset_state got %0d exp %0d", dbg_state, IDLE); else n_pass++;
        n_checks++; if (dbg_count !== 8'd0) $display("FAIL reset_count got %0d exp 0", dbg_count); else n_pass++;
        n_checks++; if (clk_out !== 1'b0) $display("FAIL reset_clk_out got %0b exp 0", clk_out); else n_pass++;
        n_checks++; if (tick !== 1'b0) $display("FAIL reset_tick got %0b exp 0", tick); else n_pass++;
        n_checks++; if (cfg_err !== 1'b0) $display("FAIL reset_cfg_err got %0b exp 0", cfg_err); else n_pass++;
        n_checks++; if (dbg_pend_vld !== 1'b0) $display("FAIL reset_pend got %0b exp 0", dbg_pend_vld); else n_pass++;
        n_checks++; if (cur_div !== 8'd0) $display("FAIL reset_cur_div got %0d exp 0", cur_div); else n_pass++;
        n_checks++; if (running !== 1'b0) $display("FAIL reset_running got %0b exp 0", running); else n_pass++;
        n_checks++; if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready got %0b exp 1", cfg_ready); else n_pass++;
        reset = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
    endtask

    task automatic test_basic();
        int start, e;
        logic [31:0] exp_t;
        start_run(8'd5, start);
        n_checks++; if (cur_div !== 8'd5) $display("FAIL basic_cur_div got %0d exp 5", cur_div); else n_pass++;
        n_checks++; if (running !== 1'b1) $display("FAIL basic_running got %0b exp 1", running); else n_pass++;
        for (int i = 1; i <= 6; i++) exp_q.push_back(32'(start + 5 * i));
        for (int j = 0; j < 32; j++) begin
            clk_step();
            e = cyc - start;
            if (tick === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL basic_extra_tick got tick at %0d exp none", e);
                else begin
                    exp_t = exp_q.pop_front();
                    if (32'(cyc) !== exp_t) $display("FAIL basic_tick_time got %0d exp %0d", cyc, exp_t); else n_pass++;
                end
            end
            n_checks++; if (clk_out !== 1'((e / 5) % 2)) $display("FAIL basic_clk_out e=%0d got %0b exp %0b", e, clk_out, 1'((e / 5) % 2)); else n_pass++;
            n_checks++; if (dbg_count !== 8'(e % 5)) $display("FAIL basic_count e=%0d got %0d exp %0d", e, dbg_count, e % 5); else n_pass++;
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL basic_missing_ticks got %0d left exp 0", exp_q.size()); else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_ratio_change();
        int start, e;
        logic exp_tick;
        start_run(8'd5, start);
        clk_step();
        cfg_valid = 1'b1; cfg_div = 8'd3;
        clk_step();
        cfg_valid = 1'b0;
        for (e = 2; e <= 15; e++) begin
            if (e > 2) clk_step();
            exp_tick = (e == 5) || (e > 5 && (e - 5) % 3 == 0);
            n_checks++; if (tick !== exp_tick) $display("FAIL chg_tick e=%0d got %0b exp %0b", e, tick, exp_tick); else n_pass++;
            n_checks++; if (cfg_ready !== (e >= 5)) $display("FAIL chg_ready e=%0d got %0b exp %0b", e, cfg_ready, e >= 5); else n_pass++;
            n_checks++; if (cur_div !== (e >= 5 ? 8'd3 : 8'd5)) $display("FAIL chg_cur_div e=%0d got %0d exp %0d", e, cur_div, e >= 5 ? 3 : 5); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int start, e;
        logic exp_tick, exp_rdy;
        logic [W-1:0] exp_cur;
        start_run(8'd4, start);
        for (e = 1; e <= 21; e++) begin
            cfg_valid = (e == 4) || (e == 9);
            cfg_div   = (e == 4) ? 8'd6 : 8'd3;
            clk_step();
            exp_tick = (e == 4) || (e == 8) || (e == 14) || (e == 17) || (e == 20);
            exp_rdy  = (e < 4) || (e == 8) || (e >= 14);
            exp_cur  = (e < 8) ? 8'd4 : ((e < 14) ? 8'd6 : 8'd3);
            n_checks++; if (tick !== exp_tick) $display("FAIL b2b_tick e=%0d got %0b exp %0b", e, tick, exp_tick); else n_pass++;
            n_checks++; if (cfg_ready !== exp_rdy) $display("FAIL b2b_ready e=%0d got %0b exp %0b", e, cfg_ready, exp_rdy); else n_pass++;
            n_checks++; if (cur_div !== exp_cur) $display("FAIL b2b_cur_div e=%0d got %0d exp %0d", e, cur_div, exp_cur); else n_pass++;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_reject();
        logic [W-1:0] bad_vals[2];
        int start;
        bad_vals[0] = 8'd1;
        bad_vals[1] = 8'd0;
        do_reset();
        cfg_valid = 1'b1; cfg_div = 8'd6;
        clk_step();
        for (int i = 0; i < 2; i++) begin
            cfg_valid = 1'b1; cfg_div = bad_vals[i];
            clk_step();
            cfg_valid = 1'b0;
            n_checks++; if (cfg_err !== 1'b1) $display("FAIL rej_err_%0d got %0b exp 1", bad_vals[i], cfg_err); else n_pass++;
            n_checks++; if (cur_div !== 8'd6) $display("FAIL rej_cur_div_%0d got %0d exp 6", bad_vals[i], cur_div); else n_pass++;
            n_checks++; if (cfg_ready !== 1'b1) $display("FAIL rej_ready_%0d got %0b exp 1", bad_vals[i], cfg_ready); else n_pass++;
            clk_step();
            n_checks++; if (cfg_err !== 1'b0) $display("FAIL rej_err_clear_%0d got %0b exp 0", bad_vals[i], cfg_err); else n_pass++;
        end
        start_run(8'd6, start);
        cfg_valid = 1'b1; cfg_div = 8'd1;
        clk_step();
        cfg_valid = 1'b0;
        n_checks++; if (cfg_err !== 1'b1) $display("FAIL rej_run_err got %0b exp 1", cfg_err); else n_pass++;
        n_checks++; if (dbg_pend_vld !== 1'b0) $display("FAIL rej_run_pend got %0b exp 0", dbg_pend_vld); else n_pass++;
        repeat (5) clk_step();
        n_checks++; if (tick !== 1'b1 || cur_div !== 8'd6) $display("FAIL rej_run_period got tick=%0b div=%0d exp tick=1 div=6", tick, cur_div); else n_pass++;
    endtask

    task automatic test_drain();
        int start, e;
        state_e exp_st;
        start_run(8'd4, start);
        repeat (4) clk_step();
        n_checks++; if (clk_out !== 1'b1) $display("FAIL drain_rise got %0b exp 1", clk_out); else n_pass++;
        enable = 1'b0;
        for (e = 5; e <= 11; e++) begin
            clk_step();
            if (e == 6) enable = 1'b1;
            if (e == 8) enable = 1'b0;
            exp_st = (e < 8) ? DRAIN : IDLE;
            n_checks++; if (tick !== (e == 8)) $display("FAIL drain_tick e=%0d got %0b exp %0b", e, tick, e == 8); else n_pass++;
            n_checks++; if (clk_out !== (e < 8)) $display("FAIL drain_clk_out e=%0d got %0b exp %0b", e, clk_out, e < 8); else n_pass++;
            n_checks++; if (running !== (e < 8)) $display("FAIL drain_running e=%0d got %0b exp %0b", e, running, e < 8); else n_pass++;
            n_checks++; if (dbg_state !== exp_st) $display("FAIL drain_state e=%0d got %0d exp %0d", e, dbg_state, exp_st); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_run();
        int start;
        start_run(8'd7, start);
        repeat (13) clk_step();
        n_checks++; if (dbg_count !== 8'd6 || clk_out !== 1'b1) $display("FAIL midrst_pre got count=%0d clk=%0b exp count=6 clk=1", dbg_count, clk_out); else n_pass++;
        reset = 1'b1;
        clk_step();
        reset = 1'b0;
        n_checks++; if (dbg_state !== IDLE) $display("FAIL midrst_state got %0d exp %0d", dbg_state, IDLE); else n_pass++;
        n_checks++; if (dbg_count !== 8'd0) $display("FAIL midrst_count got %0d exp 0", dbg_count); else n_pass++;
        n_checks++; if (clk_out !== 1'b0) $display("FAIL midrst_clk_out got %0b exp 0", clk_out); else n_pass++;
        n_checks++; if (tick !== 1'b0) $display("FAIL midrst_tick got %0b exp 0", tick); else n_pass++;
        n_checks++; if (running !== 1'b0) $display("FAIL midrst_running got %0b exp 0", running); else n_pass++;
        enable = 1'b0;
    endtask

    task automatic test_max_ratio();
        int start, e;
        start_run(8'd255, start);
        for (int j = 0; j < 520; j++) begin
            clk_step();
            e = cyc - start;
            n_checks++; if (tick !== (e % 255 == 0)) $display("FAIL max_tick e=%0d got %0b exp %0b", e, tick, e % 255 == 0); else n_pass++;
            n_checks++; if (dbg_count !== 8'(e % 255)) $display("FAIL max_count e=%0d got %0d exp %0d", e, dbg_count, e % 255); else n_pass++;
        end
        enable = 1'b0;
    endtask

    task automatic test_random();
        logic exp_rdy;
        int exp_cnt;
        do_reset();
        enable = 1'b1;
        for (int j = 0; j < 3000; j++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_div   = 8'($urandom_range(0, 12));
            clk_step();
            exp_rdy = (m_pend == 0) && !m_stopping;
            exp_cnt = m_active ? (m_n - (m_next - cyc)) : 0;
            n_checks++; if (tick !== m_tick) $display("FAIL rnd_tick c=%0d got %0b exp %0b", cyc, tick, m_tick); else n_pass++;
            n_checks++; if (clk_out !== m_level) $display("FAIL rnd_clk_out c=%0d got %0b exp %0b", cyc, clk_out, m_level); else n_pass++;
            n_checks++; if (cfg_err !== m_err) $display("FAIL rnd_cfg_err c=%0d got %0b exp %0b", cyc, cfg_err, m_err); else n_pass++;
            n_checks++; if (cfg_ready !== exp_rdy) $display("FAIL rnd_ready c=%0d got %0b exp %0b", cyc, cfg_ready, exp_rdy); else n_pass++;
            n_checks++; if (cur_div !== 8'(m_n)) $display("FAIL rnd_cur_div c=%0d got %0d exp %0d", cyc, cur_div, m_n); else n_pass++;
            n_checks++; if (running !== m_active) $display("FAIL rnd_running c=%0d got %0b exp %0b", cyc, running, m_active); else n_pass++;
            n_checks++; if (dbg_count !== 8'(exp_cnt)) $display("FAIL rnd_count c=%0d got %0d exp %0d", cyc, dbg_count, exp_cnt); else n_pass++;
        end
        reset = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_ratio_change();
        test_back_to_back();
        test_reject();
        test_drain();
        test_reset_mid_run();
        test_max_ratio();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
